// File: rtl/acq_burst_gen_pkg.sv
// Shared definitions for the acquisition burst generator: FSM state
// encodings and default widths used by the top and its helpers.
package acq_burst_gen_pkg;

   localparam int DEF_DW   = 8;
   localparam int DEF_LW   = 13;
   localparam int DEF_DLYW = 16;
   localparam int DEF_FCW  = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DELAY   = 2'd1,
      ST_CAPTURE = 2'd2
   } state_t;

endpackage

// File: rtl/acq_burst_gen_trig_sync_edge.sv
// Three-flop synchroniser for an asynchronous input with a rising-edge
// pulse taken from the last two stages. Flops reset to 1 so an input that
// is already high when reset releases is not mistaken for a fresh edge.
module trig_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise
);

   logic s1;
   logic s2;
   logic s3;

   // shift the async input through the synchroniser chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
      end else begin
         s1 <= din;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // one-cycle pulse on a synchronised low-to-high transition
   always_comb begin
      rise = s2 & ~s3;
   end

endmodule

// File: rtl/acq_burst_gen.sv
// Acquisition burst generator: on a synchronised trigger edge, waits a
// programmable delay, then streams a programmable number of ADC samples
// as a write burst. Samples are real-time, so a full downstream drops the
// sample and raises a sticky overrun flag instead of stalling.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for an accepted trigger edge
// ST_DELAY   | counting down the latched delay before the first capture
// ST_CAPTURE | one sample per cycle until len_reg samples have passed
module acq_burst_gen
   import acq_burst_gen_pkg::*;
#(
   parameter int DW   = DEF_DW,
   parameter int LW   = DEF_LW,
   parameter int DLYW = DEF_DLYW,
   parameter int FCW  = DEF_FCW
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_en,
   input  logic            i_trig,
   input  logic [DW-1:0]   i_adc_data,
   input  logic [DLYW-1:0] i_delay,
   input  logic [LW-1:0]   i_len,
   input  logic            i_full,
   output logic [DW-1:0]   o_data,
   output logic            o_wr,
   output logic            o_busy,
   output logic            o_overrun,
   output logic            o_missed,
   output logic [FCW-1:0]  o_frame_cnt
);

   state_t          state;
   logic [DLYW-1:0] dly_cnt;
   logic [LW-1:0]   len_reg;
   logic [LW-1:0]   smp_cnt;
   logic            trig_rise;

   trig_sync_edge u_trig_sync (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .din   (i_trig),
      .rise  (trig_rise)
   );

   // burst sequencing FSM with registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= ST_IDLE;
         dly_cnt     <= '0;
         len_reg     <= '0;
         smp_cnt     <= '0;
         o_data      <= '0;
         o_wr        <= 1'b0;
         o_busy      <= 1'b0;
         o_overrun   <= 1'b0;
         o_missed    <= 1'b0;
         o_frame_cnt <= '0;
      end else begin
         o_wr     <= 1'b0;
         o_missed <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (trig_rise) begin
                  if (i_en && (i_len != '0)) begin
                     dly_cnt     <= i_delay;
                     len_reg     <= i_len;
                     smp_cnt     <= '0;
                     o_frame_cnt <= o_frame_cnt + 1'b1;
                     o_overrun   <= 1'b0;
                     o_busy      <= 1'b1;
                     state       <= (i_delay != '0) ? ST_DELAY : ST_CAPTURE;
                  end else begin
                     o_missed <= 1'b1;
                  end
               end
            end
            ST_DELAY: begin
               if (trig_rise) begin
                  o_missed <= 1'b1;
               end
               // leaving on the count of 1 makes the delay exactly D cycles
               if (dly_cnt == DLYW'(1)) begin
                  state <= ST_CAPTURE;
               end
               dly_cnt <= dly_cnt - 1'b1;
            end
            ST_CAPTURE: begin
               if (trig_rise) begin
                  o_missed <= 1'b1;
               end
               o_data <= i_adc_data;
               o_wr   <= ~i_full;
               if (i_full) begin
                  o_overrun <= 1'b1;
               end
               // the sample slot is consumed whether or not it was written
               if (smp_cnt == len_reg - 1'b1) begin
                  state  <= ST_IDLE;
                  o_busy <= 1'b0;
               end
               smp_cnt <= smp_cnt + 1'b1;
            end
            default: begin
               state  <= ST_IDLE;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_acq_burst_gen.sv
// Directed bench for acq_burst_gen. Edges are numbered by cyc, the count of
// rising clock edges; outputs are sampled on the falling edge. The ADC input
// carries the previous edge number, so a sample captured on edge e reads e-1.
module tb_acq_burst_gen;

   localparam int DW   = 8;
   localparam int LW   = 13;
   localparam int DLYW = 16;
   localparam int FCW  = 16;

   logic            i_clk = 1'b0;
   logic            i_rst_n;
   logic            i_en;
   logic            i_trig;
   logic [DW-1:0]   i_adc_data;
   logic [DLYW-1:0] i_delay;
   logic [LW-1:0]   i_len;
   logic            i_full;
   logic [DW-1:0]   o_data;
   logic            o_wr;
   logic            o_busy;
   logic            o_overrun;
   logic            o_missed;
   logic [FCW-1:0]  o_frame_cnt;

   logic [DW-1:0]   w_data;
   logic            w_wr;
   logic            w_busy;
   logic            w_overrun;
   logic            w_missed;
   logic [1:0]      w_frame_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int exp_frames = 0;

   int wr_cnt, first_wr, last_wr, data_err, missed_cnt, busy_fall;
   logic busy_d = 1'b0;
   int k, k2, wr_snap;

   acq_burst_gen #(.DW(DW), .LW(LW), .DLYW(DLYW), .FCW(FCW)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_en        (i_en),
      .i_trig      (i_trig),
      .i_adc_data  (i_adc_data),
      .i_delay     (i_delay),
      .i_len       (i_len),
      .i_full      (i_full),
      .o_data      (o_data),
      .o_wr        (o_wr),
      .o_busy      (o_busy),
      .o_overrun   (o_overrun),
      .o_missed    (o_missed),
      .o_frame_cnt (o_frame_cnt)
   );

   // narrow frame counter instance so wrap-around is reachable quickly
   acq_burst_gen #(.DW(DW), .LW(LW), .DLYW(DLYW), .FCW(2)) dut_w (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_en        (i_en),
      .i_trig      (i_trig),
      .i_adc_data  (i_adc_data),
      .i_delay     (i_delay),
      .i_len       (i_len),
      .i_full      (i_full),
      .o_data      (w_data),
      .o_wr        (w_wr),
      .o_busy      (w_busy),
      .o_overrun   (w_overrun),
      .o_missed    (w_missed),
      .o_frame_cnt (w_frame_cnt)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   always @(negedge i_clk) i_adc_data = DW'(cyc);

   // observe the main instance once per cycle
   always @(negedge i_clk) begin
      if (o_wr) begin
         if (wr_cnt == 0) first_wr = cyc;
         last_wr = cyc;
         wr_cnt++;
         if (o_data != DW'(cyc - 1)) data_err++;
      end
      if (o_missed) missed_cnt++;
      if (busy_d && !o_busy) busy_fall = cyc;
      busy_d = o_busy;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clr();
      @(posedge i_clk);
      #1;
      wr_cnt = 0; first_wr = -1; last_wr = -1; data_err = 0;
      missed_cnt = 0; busy_fall = -1;
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   // trigger high on edges k and k+1; returns k
   task automatic fire(output int kk);
      @(negedge i_clk);
      i_trig = 1'b1;
      @(negedge i_clk);
      kk = cyc;
      @(negedge i_clk);
      i_trig = 1'b0;
   endtask

   task automatic chk_frames(input string tag);
      chk({tag, "_frame"}, 32'(o_frame_cnt), 32'(exp_frames % 65536));
      chk({tag, "_frame_w"}, 32'(w_frame_cnt), 32'(exp_frames % 4));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst_n = 1'b0; i_en = 1'b1; i_trig = 1'b1; i_delay = '0;
      i_len = LW'(10); i_full = 1'b0; i_adc_data = '0;
      wr_cnt = 0; first_wr = -1; last_wr = -1; data_err = 0;
      missed_cnt = 0; busy_fall = -1;
      run(3);
      chk("rst_wr", 32'(o_wr), 0);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_data", 32'(o_data), 0);
      chk("rst_ovr", 32'(o_overrun), 0);
      chk("rst_missed", 32'(o_missed), 0);
      chk_frames("rst");

      // trigger held high through reset release must not fire
      i_rst_n = 1'b1;
      run(10);
      chk("hold_wr", 32'(wr_cnt), 0);
      chk("hold_busy", 32'(o_busy), 0);
      chk("hold_missed", 32'(missed_cnt), 0);
      chk_frames("hold");
      i_trig = 1'b0;
      run(4);

      // basic burst, no delay
      clr();
      i_delay = '0; i_len = LW'(10);
      fire(k);
      exp_frames++;
      run(25);
      chk("b1_cnt", 32'(wr_cnt), 10);
      chk("b1_first", 32'(first_wr), 32'(k + 3));
      chk("b1_last", 32'(last_wr), 32'(k + 12));
      chk("b1_data", 32'(data_err), 0);
      chk("b1_busy_fall", 32'(busy_fall), 32'(k + 12));
      chk("b1_busy", 32'(o_busy), 0);
      chk("b1_ovr", 32'(o_overrun), 0);
      chk_frames("b1");

      // burst after a delay of 5
      clr();
      i_delay = DLYW'(5); i_len = LW'(4);
      fire(k);
      exp_frames++;
      run(25);
      chk("b2_cnt", 32'(wr_cnt), 4);
      chk("b2_first", 32'(first_wr), 32'(k + 8));
      chk("b2_last", 32'(last_wr), 32'(k + 11));
      chk("b2_data", 32'(data_err), 0);
      chk("b2_missed", 32'(missed_cnt), 0);
      chk_frames("b2");

      // downstream full for the third and fourth samples
      clr();
      i_delay = '0; i_len = LW'(10);
      fire(k);
      exp_frames++;
      repeat (25) begin
         @(negedge i_clk);
         i_full = (cyc == k + 4) || (cyc == k + 5);
      end
      i_full = 1'b0;
      chk("b3_cnt", 32'(wr_cnt), 8);
      chk("b3_last", 32'(last_wr), 32'(k + 12));
      chk("b3_busy_fall", 32'(busy_fall), 32'(k + 12));
      chk("b3_data", 32'(data_err), 0);
      chk("b3_ovr", 32'(o_overrun), 1);
      run(10);
      chk("b3_ovr_hold", 32'(o_overrun), 1);
      clr();
      i_len = LW'(2);
      fire(k);
      exp_frames++;
      run(12);
      chk("b3_ovr_clr", 32'(o_overrun), 0);
      chk("b3_next_cnt", 32'(wr_cnt), 2);

      // second edge during capture is missed, burst unaffected
      clr();
      i_len = LW'(10);
      fire(k);
      exp_frames++;
      run(1);
      fire(k2);
      run(25);
      chk("b4_cnt", 32'(wr_cnt), 10);
      chk("b4_first", 32'(first_wr), 32'(k + 3));
      chk("b4_missed", 32'(missed_cnt), 1);
      chk_frames("b4");

      // trigger while disabled
      clr();
      i_en = 1'b0;
      fire(k);
      run(10);
      i_en = 1'b1;
      chk("dis_cnt", 32'(wr_cnt), 0);
      chk("dis_missed", 32'(missed_cnt), 1);
      chk("dis_busy_fall", 32'(busy_fall), 32'(-1));
      chk_frames("dis");

      // zero-length trigger
      clr();
      i_len = '0;
      fire(k);
      run(10);
      chk("len0_cnt", 32'(wr_cnt), 0);
      chk("len0_missed", 32'(missed_cnt), 1);
      chk_frames("len0");

      // reset mid-burst drops outputs at once and stops the burst
      clr();
      i_len = LW'(10);
      fire(k);
      while (cyc < k + 5) @(negedge i_clk);
      #2;
      i_rst_n = 1'b0;
      exp_frames = 0;
      #1;
      chk("arst_wr", 32'(o_wr), 0);
      chk("arst_busy", 32'(o_busy), 0);
      wr_snap = wr_cnt;
      chk("arst_cnt", 32'(wr_snap), 3);
      run(3);
      i_rst_n = 1'b1;
      run(15);
      chk("arst_after", 32'(wr_cnt), 3);
      chk_frames("arst");

      clr();
      i_len = LW'(5);
      fire(k);
      exp_frames++;
      run(15);
      chk("post_cnt", 32'(wr_cnt), 5);
      chk("post_first", 32'(first_wr), 32'(k + 3));
      chk_frames("post");

      // three more accepted bursts wrap the two-bit frame counter to 0
      i_len = LW'(1);
      repeat (3) begin
         fire(k);
         exp_frames++;
         run(6);
      end
      chk("wrap_w", 32'(w_frame_cnt), 0);
      chk("wrap_main", 32'(o_frame_cnt), 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
